// File: rtl/axi2per_res_channel.sv
// Response half of the AXI-to-peripheral bridge: latches in-flight transaction info,
// buffers the single peripheral response and retires it on AXI R or B. Optional macro: AXI2PER_SLVERR_EN.
module axi2per_res_channel #(
  parameter int unsigned PER_ADDR_WIDTH = 32,
  parameter int unsigned PER_DATA_WIDTH = 32,
  parameter int unsigned PER_ID_WIDTH   = 5,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned AXI_ID_WIDTH   = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic                      per_slave_r_valid_i,
  input  logic                      per_slave_r_opc_i,
  input  logic [PER_ID_WIDTH-1:0]   per_slave_r_id_i,
  input  logic [PER_DATA_WIDTH-1:0] per_slave_r_rdata_i,

  input  logic                      trans_req_i,
  input  logic                      trans_we_i,
  input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i,
  output logic                      trans_r_valid_o,

  output logic                      axi_slave_r_valid_o,
  output logic [AXI_DATA_WIDTH-1:0] axi_slave_r_data_o,
  output logic [1:0]                axi_slave_r_resp_o,
  output logic                      axi_slave_r_last_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_r_id_o,
  output logic [AXI_USER_WIDTH-1:0] axi_slave_r_user_o,
  input  logic                      axi_slave_r_ready_i,

  output logic                      axi_slave_b_valid_o,
  output logic [1:0]                axi_slave_b_resp_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_b_id_o,
  output logic [AXI_USER_WIDTH-1:0] axi_slave_b_user_o,
  input  logic                      axi_slave_b_ready_i,

  output logic                      busy_o,
  output logic                      protocol_err_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_PER = 2'd1,
    RESP     = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic                      we_q, we_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic                      addr2_q, addr2_d;
  logic [PER_DATA_WIDTH-1:0] data_q, data_d;
  logic                      slverr_q, slverr_d;
  logic                      perr_q, perr_d;

  logic                      r_valid, b_valid;
  logic                      r_hs, b_hs;
  logic [1:0]                resp;
  logic [AXI_DATA_WIDTH-1:0] rdata_w;

  // Response id is not checked (single outstanding); address only contributes bit 2.
  logic unused_sink;
  assign unused_sink = ^{per_slave_r_id_i, per_slave_r_opc_i, trans_add_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      id_q     <= '0;
      addr2_q  <= 1'b0;
      data_q   <= '0;
      slverr_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      id_q     <= id_d;
      addr2_q  <= addr2_d;
      data_q   <= data_d;
      slverr_q <= slverr_d;
      perr_q   <= perr_d;
    end
  end

  assign r_valid = (state_q == RESP) &&  we_q;
  assign b_valid = (state_q == RESP) && !we_q;
  assign r_hs    = r_valid && axi_slave_r_ready_i;
  assign b_hs    = b_valid && axi_slave_b_ready_i;

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    id_d     = id_q;
    addr2_d  = addr2_q;
    data_d   = data_q;
    slverr_d = slverr_q;
    perr_d   = perr_q;
    unique case (state_q)
      IDLE: begin
        if (per_slave_r_valid_i) perr_d = 1'b1;
        if (trans_req_i) begin
          we_d    = trans_we_i;
          id_d    = trans_id_i;
          addr2_d = trans_add_i[2];
          state_d = WAIT_PER;
        end
      end
      WAIT_PER: begin
        if (trans_req_i) perr_d = 1'b1;
        if (per_slave_r_valid_i) begin
          data_d  = per_slave_r_rdata_i;
`ifdef AXI2PER_SLVERR_EN
          slverr_d = per_slave_r_opc_i;
`else
          slverr_d = 1'b0;
`endif
          state_d = RESP;
        end
      end
      RESP: begin
        if (trans_req_i || per_slave_r_valid_i) perr_d = 1'b1;
        if (r_hs || b_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A 32-bit peripheral word lands in the 64-bit lane selected by address bit 2.
  generate
    if (PER_DATA_WIDTH == 64) begin : g_w64
      assign rdata_w = data_q;
    end else begin : g_w32
      assign rdata_w = addr2_q ? {data_q, 32'h0000_0000} : {32'h0000_0000, data_q};
    end
  endgenerate

  assign resp = slverr_q ? 2'b10 : 2'b00;

  assign trans_r_valid_o     = r_hs || b_hs;

  assign axi_slave_r_valid_o = r_valid;
  assign axi_slave_r_data_o  = r_valid ? rdata_w : '0;
  assign axi_slave_r_resp_o  = r_valid ? resp : 2'b00;
  assign axi_slave_r_last_o  = r_valid;
  assign axi_slave_r_id_o    = r_valid ? id_q : '0;
  assign axi_slave_r_user_o  = '0;

  assign axi_slave_b_valid_o = b_valid;
  assign axi_slave_b_resp_o  = b_valid ? resp : 2'b00;
  assign axi_slave_b_id_o    = b_valid ? id_q : '0;
  assign axi_slave_b_user_o  = '0;

  assign busy_o              = (state_q != IDLE);
  assign protocol_err_o      = perr_q;

endmodule

// File: tb/tb_axi2per_res_channel.sv
// Directed, table-driven bench for axi2per_res_channel (32-bit peripheral data).
module tb_axi2per_res_channel;

  logic        clk = 1'b0;
  logic        rst;
  logic        per_valid, per_opc;
  logic [4:0]  per_id;
  logic [31:0] per_rdata;
  logic        req, we;
  logic [2:0]  tid;
  logic [31:0] tadd;
  logic        trv;
  logic        r_valid, r_last, r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp, b_resp;
  logic [2:0]  r_id, b_id;
  logic [5:0]  r_user, b_user;
  logic        b_valid, b_ready, busy, perr;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

`ifdef AXI2PER_SLVERR_EN
  localparam int SLV = 2;
`else
  localparam int SLV = 0;
`endif
  localparam logic [63:0] Z64 = '0;

  always #5 clk = ~clk;

  axi2per_res_channel #(
    .PER_DATA_WIDTH(32),
    .AXI_DATA_WIDTH(64)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .per_slave_r_valid_i (per_valid),
    .per_slave_r_opc_i   (per_opc),
    .per_slave_r_id_i    (per_id),
    .per_slave_r_rdata_i (per_rdata),
    .trans_req_i         (req),
    .trans_we_i          (we),
    .trans_id_i          (tid),
    .trans_add_i         (tadd),
    .trans_r_valid_o     (trv),
    .axi_slave_r_valid_o (r_valid),
    .axi_slave_r_data_o  (r_data),
    .axi_slave_r_resp_o  (r_resp),
    .axi_slave_r_last_o  (r_last),
    .axi_slave_r_id_o    (r_id),
    .axi_slave_r_user_o  (r_user),
    .axi_slave_r_ready_i (r_ready),
    .axi_slave_b_valid_o (b_valid),
    .axi_slave_b_resp_o  (b_resp),
    .axi_slave_b_id_o    (b_id),
    .axi_slave_b_user_o  (b_user),
    .axi_slave_b_ready_i (b_ready),
    .busy_o              (busy),
    .protocol_err_o      (perr)
  );

  typedef struct {
    logic        rst, pv, opc;
    logic [31:0] rdata;
    logic        req, we;
    logic [2:0]  id;
    logic [31:0] add;
    logic        rr, br;
    logic        e_trv, e_rv;
    logic [63:0] e_rd;
    logic [1:0]  e_rresp;
    logic [2:0]  e_rid;
    logic        e_bv;
    logic [1:0]  e_bresp;
    logic [2:0]  e_bid;
    logic        e_busy, e_perr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int rst_, input int pv, input int opc, input logic [31:0] rdata,
                              input int req_, input int we_, input int id, input logic [31:0] add,
                              input int rr, input int br, input int etrv, input int erv,
                              input logic [63:0] erd, input int erresp, input int erid, input int ebv,
                              input int ebresp, input int ebid, input int ebusy, input int eperr);
    vec_t v;
    v.rst = rst_[0]; v.pv = pv[0]; v.opc = opc[0]; v.rdata = rdata;
    v.req = req_[0]; v.we = we_[0]; v.id = id[2:0]; v.add = add;
    v.rr = rr[0]; v.br = br[0];
    v.e_trv = etrv[0]; v.e_rv = erv[0]; v.e_rd = erd; v.e_rresp = erresp[1:0];
    v.e_rid = erid[2:0]; v.e_bv = ebv[0]; v.e_bresp = ebresp[1:0]; v.e_bid = ebid[2:0];
    v.e_busy = ebusy[0]; v.e_perr = eperr[0];
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; per_valid = v.pv; per_opc = v.opc; per_rdata = v.rdata;
    req = v.req; we = v.we; tid = v.id; tadd = v.add;
    r_ready = v.rr; b_ready = v.br;
  endtask

  task automatic check(input string name, input vec_t v);
    logic [91:0] act, exp;
    act = {trv, r_valid, r_data, r_resp, r_last, r_id, r_user,
           b_valid, b_resp, b_id, b_user, busy, perr};
    exp = {v.e_trv, v.e_rv, v.e_rd, v.e_rresp, v.e_rv, v.e_rid, 6'd0,
           v.e_bv, v.e_bresp, v.e_bid, 6'd0, v.e_busy, v.e_perr};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got trv/rv/rdata/rresp/rlast/rid/ruser/bv/bresp/bid/buser/busy/perr=%h want %h",
               name, act, exp);
    end
  endtask

  task automatic apply(input string name, input vec_t v);
    @(posedge clk);
    #1 drive(v);
    @(negedge clk);
    check(name, v);
  endtask

  vec_t idle_v, v;
  int   waited;

  initial begin
    drive(mk(1,0,0,0,0,0,0,0,0,0, 0,0,Z64,0,0,0,0,0,0,0));
    per_id = 5'd0;
    repeat (2) @(posedge clk);

    idle_v = mk(0,0,0,0,0,0,0,0,0,0, 0,0,Z64,0,0,0,0,0,0,0);
    // read, addr bit2=1, id 3
    vecs.push_back(idle_v);
    vecs.push_back(mk(0,0,0,0,1,1,3,32'h1000_0004,0,0, 0,0,Z64,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,Z64,0,0,0,0,0,1,0));
    vecs.push_back(mk(0,1,0,32'hDEAD_BEEF,0,0,0,0,0,0, 0,0,Z64,0,0,0,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1,0, 1,1,64'hDEAD_BEEF_0000_0000,0,3,0,0,0,1,0));
    vecs.push_back(idle_v);
    // write id 5, b_ready low for 10 cycles while r_ready is high
    vecs.push_back(mk(0,0,0,0,1,0,5,0,0,0, 0,0,Z64,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,32'h1234_5678,0,0,0,0,0,0, 0,0,Z64,0,0,0,0,0,1,0));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(0,0,0,0,0,0,0,0,1,0, 0,0,Z64,0,0,1,0,5,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1, 1,0,Z64,0,0,1,0,5,1,0));
    // back-to-back read (opc=1) then write
    vecs.push_back(mk(0,0,0,0,1,1,1,0,0,0, 0,0,Z64,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,1,32'hCAFE_F00D,0,0,0,0,0,0, 0,0,Z64,0,0,0,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1,0, 1,1,64'h0000_0000_CAFE_F00D,SLV,1,0,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,1,0,6,32'h4,0,0, 0,0,Z64,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,32'h5555_AAAA,0,0,0,0,0,0, 0,0,Z64,0,0,0,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1, 1,0,Z64,0,0,1,0,6,1,0));
    vecs.push_back(idle_v);
    // stray peripheral response in IDLE
    vecs.push_back(mk(0,1,0,32'h7777_7777,0,0,0,0,0,0, 0,0,Z64,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,Z64,0,0,0,0,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,Z64,0,0,0,0,0,0,1));
    // reset while stalled in RESP, then a fresh read
    vecs.push_back(mk(0,0,0,0,1,1,2,32'h4,0,0, 0,0,Z64,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,32'h1111_2222,0,0,0,0,0,0, 0,0,Z64,0,0,0,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,1,64'h1111_2222_0000_0000,0,2,0,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,1,64'h1111_2222_0000_0000,0,2,0,0,0,1,0));
    vecs.push_back(idle_v);
    vecs.push_back(mk(0,0,0,0,1,1,7,0,0,0, 0,0,Z64,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,32'hA5A5_A5A5,0,0,0,0,0,0, 0,0,Z64,0,0,0,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1,0, 1,1,64'h0000_0000_A5A5_A5A5,0,7,0,0,0,1,0));
    vecs.push_back(idle_v);
    // request while waiting on the peripheral is a protocol error and is ignored
    vecs.push_back(mk(0,0,0,0,1,1,4,0,0,0, 0,0,Z64,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,1,32'h4,0,0, 0,0,Z64,0,0,0,0,0,1,0));
    vecs.push_back(mk(0,1,0,32'h0F0F_0F0F,0,0,0,0,0,0, 0,0,Z64,0,0,0,0,0,1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1,0, 1,1,64'h0000_0000_0F0F_0F0F,0,4,0,0,0,1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,Z64,0,0,0,0,0,0,1));

    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

    // Hand sequence: reset, then read at addr bit2=1 with r_ready held low; payload must hold.
    apply("seq_rst", mk(1,0,0,0,0,0,0,0,0,0, 0,0,Z64,0,0,0,0,0,0,1));
    apply("seq_req", mk(0,0,0,0,1,1,6,32'hFFFF_FFFC,0,0, 0,0,Z64,0,0,0,0,0,0,0));
    apply("seq_per", mk(0,1,1,32'h8765_4321,0,0,0,0,0,0, 0,0,Z64,0,0,0,0,0,1,0));
    @(posedge clk);
    #1 drive(idle_v);
    waited = 0;
    while (!r_valid && waited < 8) begin
      @(posedge clk);
      #1 waited++;
    end
    n_vec++;
    if (!r_valid) begin
      n_bad++;
      $display("FAIL seq_rvalid_timeout: r_valid=%b after %0d cycles, want 1", r_valid, waited);
    end
    v = mk(0,0,0,0,0,0,0,0,0,0, 0,1,64'h8765_4321_0000_0000,SLV,6,0,0,0,1,0);
    for (int i = 0; i < 4; i++) apply($sformatf("seq_stall%0d", i), v);
    apply("seq_hs", mk(0,0,0,0,0,0,0,0,1,0, 1,1,64'h8765_4321_0000_0000,SLV,6,0,0,0,1,0));
    apply("seq_idle", idle_v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/axi2per_res_channel.md
Name: axi2per_res_channel

Overview:
- Response half of the AXI-to-peripheral bridge; sits directly downstream of the request channel.
- Latches the in-flight transaction info (id, type, address) when a request is granted.
- Captures the single peripheral response, buffers it, and presents it on the AXI R channel (reads) or B channel (writes).
- Pulses trans_r_valid_o on AXI handshake so the request channel can issue the next transaction.

Parameters:
PER_ADDR_WIDTH, 32, peripheral address width
PER_DATA_WIDTH, 32, peripheral data width; only 32 and 64 are legal
PER_ID_WIDTH, 5, peripheral response id width
AXI_ADDR_WIDTH, 32, AXI address width
AXI_DATA_WIDTH, 64, AXI data width; fixed at 64
AXI_USER_WIDTH, 6, AXI user width
AXI_ID_WIDTH, 3, AXI id width

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
per_slave_r_valid_i  in  1  peripheral response valid (single-cycle pulse, cannot be stalled)
per_slave_r_opc_i  in  1  peripheral response status, 1 = error
per_slave_r_id_i  in  PER_ID_WIDTH  peripheral response id (ignored, single outstanding)
per_slave_r_rdata_i  in  PER_DATA_WIDTH  peripheral read data
trans_req_i  in  1  request channel granted a transaction this cycle
trans_we_i  in  1  transaction type: 1 = READ, 0 = WRITE
trans_id_i  in  AXI_ID_WIDTH  AXI id of the granted transaction
trans_add_i  in  AXI_ADDR_WIDTH  address of the granted transaction
trans_r_valid_o  out  1  transaction retired (AXI R or B handshake this cycle)
axi_slave_r_valid_o  out  1  R valid
axi_slave_r_data_o  out  AXI_DATA_WIDTH  R data
axi_slave_r_resp_o  out  2  R response
axi_slave_r_last_o  out  1  R last
axi_slave_r_id_o  out  AXI_ID_WIDTH  R id
axi_slave_r_user_o  out  AXI_USER_WIDTH  R user, always 0
axi_slave_r_ready_i  in  1  R ready
axi_slave_b_valid_o  out  1  B valid
axi_slave_b_resp_o  out  2  B response
axi_slave_b_id_o  out  AXI_ID_WIDTH  B id
axi_slave_b_user_o  out  AXI_USER_WIDTH  B user, always 0
axi_slave_b_ready_i  in  1  B ready
busy_o  out  1  transaction in flight (state != IDLE)
protocol_err_o  out  1  sticky: unexpected peripheral response or request seen

Behaviour:
- Reset (rst_i high on a clock edge): state IDLE; all outputs 0; info and data registers cleared; protocol_err_o cleared. Applies mid-transaction: any buffered response is discarded without a handshake.
- FSM states: IDLE, WAIT_PER, RESP.
- IDLE:
  - On trans_req_i=1, register trans_we_i, trans_id_i and trans_add_i[2], then go to WAIT_PER.
  - If per_slave_r_valid_i=1 (with or without trans_req_i), drop the response and set protocol_err_o.
- WAIT_PER:
  - On per_slave_r_valid_i=1, register data and status, then go to RESP. AXI valid rises the next cycle (1-cycle latency from the peripheral response).
  - If trans_req_i=1, ignore it and set protocol_err_o.
- RESP, read (we=1):
  - axi_slave_r_valid_o=1, r_last_o=1 (single beat), r_id_o = latched id.
  - PER_DATA_WIDTH=32: rdata goes in lane [31:0] when addr[2]=0, else lane [63:32]; the other lane is 0.
  - PER_DATA_WIDTH=64: rdata is passed through unchanged.
- RESP, write (we=0): axi_slave_b_valid_o=1, b_id_o = latched id.
- RESP exit: when valid & ready, trans_r_valid_o=1 for that cycle (combinational), state -> IDLE next cycle.
  - valid and all payload held stable until the handshake.
  - If trans_req_i=1 in the handshake cycle, ignore it and set protocol_err_o.
  - Back-to-back transactions are accepted from the first IDLE cycle after retirement.
- RESP stall:
  - Any ready may stay low indefinitely; no timeout.
  - A ready arriving while the other channel is in use has no effect: R and B are never valid together.
  - If per_slave_r_valid_i=1, drop it and set protocol_err_o.
- Response code: resp = 2'b00 (OKAY), except as defined under Optional Feature.
- Payload outputs are 0 whenever the matching valid is 0.

Optional Feature:
- Macro: AXI2PER_SLVERR_EN.
- Defined: per_slave_r_opc_i=1 latches an error; r_resp_o / b_resp_o = 2'b10 (SLVERR); read data is still forwarded.
- Undefined: opc is ignored; resp is always 2'b00.

Test Plan:
- Read, addr 0x1000_0004, id 3: trans_req(we=1) -> rvalid 2 cycles later with rdata 0xDEADBEEF, r_ready=1 -> r_data=0xDEADBEEF_00000000, r_last=1, r_id=3, r_resp=00, trans_r_valid_o pulse 1 cycle, busy_o falls next cycle.
- Write, id 5, b_ready held low 10 cycles: -> b_valid stays 1 with b_id=5 for all 10 cycles; trans_r_valid_o=0 until the ready cycle; r_valid=0 throughout.
- Back-to-back read then write: second trans_req in the first cycle after retirement -> accepted; responses ordered R then B; protocol_err_o=0.
- opc=1 on read: with AXI2PER_SLVERR_EN -> r_resp=10; without -> r_resp=00.
- Stray per_slave_r_valid_i in IDLE -> no AXI valid, protocol_err_o=1 until rst_i.
- rst_i asserted while in RESP with r_ready=0 -> next cycle all valids=0, busy_o=0, state IDLE; new read completes normally.
